// File: rtl/shift_cmd_pkg.sv
// Shared definitions for the shift-register command sequencer.
//   OP_*   : command opcodes carried in cmd_op
//   S_*    : sequencer FSM state encodings
//   CNT_W  : width of the shift repeat count
//   CMD_W  : width of one packed FIFO record {op, data, count} at the default WIDTH
package shift_cmd_pkg;

   localparam logic [1:0] OP_NOP  = 2'd0;
   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_SHL  = 2'd2;
   localparam logic [1:0] OP_SHR  = 2'd3;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EXEC = 1'b1;

   localparam int unsigned CNT_W = 4;

   // Packed record width for a given data width: op + data + count.
   function automatic int unsigned cmd_w(input int unsigned width);
      return 2 + width + CNT_W;
   endfunction

   localparam int unsigned CMD_W = 2 + 4 + CNT_W;

endpackage

// File: rtl/shift_cmd_sequencer_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_flush        : synchronous clear of both pointers
//   i_push/i_wdata : write one entry (ignored when full)
//   i_pop/o_rdata  : o_rdata shows the head; i_pop consumes it (ignored when empty)
//   o_full/o_empty : occupancy flags
module cmd_fifo #(
   parameter int unsigned W     = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   // Extra MSB distinguishes full (MSBs differ) from empty (equal).
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command sequencer feeding a 4-bit shift register's d_in/ld/sl/sr inputs.
// Ports:
//   i_clk, i_reset       : clock, asynchronous active-high reset
//   i_flush              : drop all queued commands and abort the running one
//   i_cmd_valid/o_cmd_ready, i_cmd_op, i_cmd_data, i_cmd_count : command push
//   o_d_in               : last LOAD value
//   o_ld, o_sl, o_sr     : one-cycle control pulses, mutually exclusive
//   o_busy               : executing or commands pending
//   o_done               : pulse in the final cycle of each command
module shift_cmd_sequencer
   import shift_cmd_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_data,
   input  logic [CNT_W-1:0] i_cmd_count,
   output logic [WIDTH-1:0] o_d_in,
   output logic             o_ld,
   output logic             o_sl,
   output logic             o_sr,
   output logic             o_busy,
   output logic             o_done
);

   localparam int unsigned CW = cmd_w(WIDTH);

   logic [0:0]       r_state;
   logic [1:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_d_in;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_wdata;
   logic [CW-1:0]    w_head;
   logic [1:0]       w_head_op;
   logic [WIDTH-1:0] w_head_data;
   logic [CNT_W-1:0] w_head_cnt;
   logic             w_exec;
   logic             w_last;

   // A flush discards any push in the same cycle and blocks the pop.
   assign w_push  = i_cmd_valid && !w_full && !i_flush;
   assign w_pop   = (r_state == S_IDLE) && !w_empty && !i_flush;
   assign w_wdata = {i_cmd_op, i_cmd_data, i_cmd_count};

   assign w_head_op   = w_head[CW-1 -: 2];
   assign w_head_data = w_head[CNT_W +: WIDTH];
   assign w_head_cnt  = w_head[CNT_W-1:0];

   cmd_fifo #(
      .W     (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_flush),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // NOP/LOAD take one EXEC cycle; shifts end on the pulse with count 1, or at once for count 0.
   assign w_exec = (r_state == S_EXEC);
   assign w_last = (r_op == OP_NOP) || (r_op == OP_LOAD) || (r_cnt <= 4'd1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_op    <= OP_NOP;
         r_cnt   <= '0;
         r_d_in  <= '0;
      end else if (i_flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_op    <= w_head_op;
                  r_cnt   <= w_head_cnt;
                  if (w_head_op == OP_LOAD) r_d_in <= w_head_data;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               if (w_last)      r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only.
   assign o_d_in      = r_d_in;
   assign o_ld        = w_exec && (r_op == OP_LOAD);
   assign o_sl        = w_exec && (r_op == OP_SHL) && (r_cnt != '0);
   assign o_sr        = w_exec && (r_op == OP_SHR) && (r_cnt != '0);
   assign o_done      = w_exec && w_last;
   assign o_busy      = w_exec || !w_empty;
   assign o_cmd_ready = !w_full;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
module tb_shift_cmd_sequencer;
   import shift_cmd_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_data = 4'd0;
   logic [3:0] cmd_count = 4'd0;
   logic       cmd_ready, ld, sl, sr, busy, done;
   logic [3:0] d_in;

   int checks = 0;
   int failures = 0;

   // Monitor state: pulse counters, downstream shift-register model, LOAD log.
   int         n_ld = 0, n_sl = 0, n_sr = 0, n_done = 0, n_multi = 0;
   logic [3:0] q_model = 4'd0;
   logic [3:0] ld_log[$];

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic [3:0] cnt;
      int         exec;
      int         nld;
      int         nsl;
      int         nsr;
      logic [3:0] din;
      logic [3:0] q;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   shift_cmd_sequencer #(
      .WIDTH (4),
      .DEPTH (4)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_flush     (flush),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_data  (cmd_data),
      .i_cmd_count (cmd_count),
      .o_d_in      (d_in),
      .o_ld        (ld),
      .o_sl        (sl),
      .o_sr        (sr),
      .o_busy      (busy),
      .o_done      (done)
   );

   always @(negedge clk) begin
      if (reset) begin
         q_model = 4'd0;
      end else begin
         if (int'(ld) + int'(sl) + int'(sr) > 1) n_multi++;
         if (done) n_done++;
         if (ld) begin
            n_ld++;
            ld_log.push_back(d_in);
            q_model = d_in;
         end else if (sl) begin
            n_sl++;
            q_model = {q_model[2:0], 1'b0};
         end else if (sr) begin
            n_sr++;
            q_model = {1'b0, q_model[3:1]};
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
   endtask

   function automatic int code(input logic a, input logic b, input logic c);
      return a ? 1 : (b ? 2 : (c ? 3 : 0));
   endfunction

   initial begin
      int first, done_at, nl, ns, nr, k, rdy_drop, base, base_sl, base_ld, base_sr, base_done;
      int         tr[8];
      logic [3:0] qh[8];
      logic [3:0] lds[6];
      logic [3:0] cnts[6];
      logic [1:0] ops[6];
      logic       reached;

      vecs[0] = '{OP_LOAD, 4'b1011, 4'd0,  1, 1, 0, 0,  4'b1011, 4'b1011};
      vecs[1] = '{OP_SHL,  4'b0000, 4'd1,  1, 0, 1, 0,  4'b1011, 4'b0110};
      vecs[2] = '{OP_SHR,  4'b0000, 4'd1,  1, 0, 0, 1,  4'b1011, 4'b0011};
      vecs[3] = '{OP_SHR,  4'b0000, 4'd3,  3, 0, 0, 3,  4'b1011, 4'b0000};
      vecs[4] = '{OP_LOAD, 4'b0110, 4'd0,  1, 1, 0, 0,  4'b0110, 4'b0110};
      vecs[5] = '{OP_SHL,  4'b0000, 4'd0,  1, 0, 0, 0,  4'b0110, 4'b0110};
      vecs[6] = '{OP_NOP,  4'b1111, 4'd5,  1, 0, 0, 0,  4'b0110, 4'b0110};
      vecs[7] = '{OP_SHL,  4'b0000, 4'd2,  2, 0, 2, 0,  4'b0110, 4'b1000};
      vecs[8] = '{OP_LOAD, 4'b1111, 4'd0,  1, 1, 0, 0,  4'b1111, 4'b1111};
      vecs[9] = '{OP_SHR,  4'b1010, 4'd15, 15, 0, 0, 15, 4'b1111, 4'b0000};

      // Reset state
      #2;
      chk("rst_d_in", int'(d_in), 0);
      chk("rst_pulses", int'({ld, sl, sr}), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Table-driven single commands, each pushed into an idle sequencer
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].op, vecs[i].data, vecs[i].cnt);
         @(posedge clk);
         #1 cmd_valid = 1'b0;
         first = 0; done_at = 0; nl = 0; ns = 0; nr = 0;
         for (int c = 1; c <= 40 && done_at == 0; c++) begin
            @(negedge clk);
            if ((ld | sl | sr | done) && first == 0) first = c;
            nl += int'(ld);
            ns += int'(sl);
            nr += int'(sr);
            if (done) done_at = c;
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_latency", i), first, 2);
         chk($sformatf("v%0d_exec", i), done_at - first + 1, vecs[i].exec);
         chk($sformatf("v%0d_ld", i), nl, vecs[i].nld);
         chk($sformatf("v%0d_sl", i), ns, vecs[i].nsl);
         chk($sformatf("v%0d_sr", i), nr, vecs[i].nsr);
         chk($sformatf("v%0d_d_in", i), int'(d_in), int'(vecs[i].din));
         chk($sformatf("v%0d_q", i), int'(q_model), int'(vecs[i].q));
         chk($sformatf("v%0d_busy", i), int'(busy), 0);
      end

      // Back-to-back LOAD 1011, SHL 1, SHR 1
      drive(OP_LOAD, 4'b1011, 4'd0);
      @(posedge clk);
      #1 drive(OP_SHL, 4'b0000, 4'd1);
      @(negedge clk);
      tr[1] = code(ld, sl, sr);
      #1 qh[1] = q_model;
      @(posedge clk);
      #1 drive(OP_SHR, 4'b0000, 4'd1);
      @(negedge clk);
      tr[2] = code(ld, sl, sr);
      #1 qh[2] = q_model;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int c = 3; c <= 7; c++) begin
         @(negedge clk);
         tr[c] = code(ld, sl, sr);
         #1 qh[c] = q_model;
      end
      chk("b2b_c1", tr[1], 0);
      chk("b2b_c2_ld", tr[2], 1);
      chk("b2b_c3", tr[3], 0);
      chk("b2b_c4_sl", tr[4], 2);
      chk("b2b_c5", tr[5], 0);
      chk("b2b_c6_sr", tr[6], 3);
      chk("b2b_c7", tr[7], 0);
      chk("b2b_q_after_ld", int'(qh[2]), 4'b1011);
      chk("b2b_q_after_sl", int'(qh[4]), 4'b0110);
      chk("b2b_q_after_sr", int'(qh[6]), 4'b0011);
      repeat (2) @(posedge clk);
      #1;

      // Overfill: SHL 10 then LOAD 1..5 with cmd_valid held
      ops[0] = OP_SHL; lds[0] = 4'd0; cnts[0] = 4'd10;
      for (int j = 1; j < 6; j++) begin
         ops[j] = OP_LOAD;
         lds[j] = 4'(j);
         cnts[j] = 4'd0;
      end
      base = ld_log.size();
      base_sl = n_sl;
      k = 0;
      rdy_drop = -1;
      for (int g = 0; g < 200 && k < 6; g++) begin
         drive(ops[k], lds[k], cnts[k]);
         @(negedge clk);
         if (!cmd_ready && rdy_drop < 0) rdy_drop = k;
         reached = cmd_ready;
         @(posedge clk);
         #1;
         if (reached) k++;
      end
      cmd_valid = 1'b0;
      chk("fill_all_pushed", k, 6);
      chk("fill_ready_drop_at", rdy_drop, 5);
      reached = 1'b0;
      for (int g = 0; g < 100 && !reached; g++) begin
         @(posedge clk);
         #1 reached = !busy;
      end
      chk("fill_drained", int'(reached), 1);
      chk("fill_ld_count", ld_log.size() - base, 5);
      chk("fill_sl_count", n_sl - base_sl, 10);
      for (int j = 0; j < 5; j++) begin
         if (base + j < ld_log.size())
            chk($sformatf("fill_order%0d", j), int'(ld_log[base + j]), j + 1);
         else
            chk($sformatf("fill_order%0d", j), -1, j + 1);
      end
      chk("fill_d_in", int'(d_in), 5);

      // Flush in the middle of SHL 10 with two LOADs queued
      base_sl = n_sl; base_ld = n_ld; base_done = n_done;
      drive(OP_SHL, 4'b0000, 4'd10);
      @(posedge clk);
      #1 drive(OP_LOAD, 4'b1010, 4'd0);
      @(posedge clk);
      #1 drive(OP_LOAD, 4'b1100, 4'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      reached = 1'b0;
      for (int g = 0; g < 30 && !reached; g++) begin
         reached = (n_sl - base_sl >= 3);
         if (!reached) begin
            @(posedge clk);
            #1;
         end
      end
      chk("flush_reached", int'(reached), 1);
      flush = 1'b1;
      drive(OP_LOAD, 4'b1111, 4'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      cmd_valid = 1'b0;
      chk("flush_busy", int'(busy), 0);
      chk("flush_pulses", int'({ld, sl, sr}), 0);
      chk("flush_ready", int'(cmd_ready), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("flush_sl_count", n_sl - base_sl, 4);
      chk("flush_no_ld", n_ld - base_ld, 0);
      chk("flush_no_done", n_done - base_done, 0);
      chk("flush_d_in", int'(d_in), 5);

      // Asynchronous reset in the middle of SHR 10
      base_sr = n_sr;
      drive(OP_LOAD, 4'b1110, 4'd0);
      @(posedge clk);
      #1 drive(OP_SHR, 4'b0000, 4'd10);
      @(posedge clk);
      #1 drive(OP_LOAD, 4'b0011, 4'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      reached = 1'b0;
      for (int g = 0; g < 30 && !reached; g++) begin
         reached = (n_sr - base_sr >= 2);
         if (!reached) begin
            @(posedge clk);
            #1;
         end
      end
      chk("arst_reached", int'(reached), 1);
      chk("arst_sr_before", int'(sr), 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_sr", int'(sr), 0);
      chk("arst_ld_done", int'({ld, done}), 0);
      chk("arst_d_in", int'(d_in), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_ready", int'(cmd_ready), 1);
      @(negedge clk);
      #2 reset = 1'b0;
      base_ld = n_ld; base_sr = n_sr; base_done = n_done;
      repeat (20) @(posedge clk);
      #1;
      chk("arst_fifo_empty_ld", n_ld - base_ld, 0);
      chk("arst_fifo_empty_sr", n_sr - base_sr, 0);
      chk("arst_no_done", n_done - base_done, 0);
      chk("arst_idle_busy", int'(busy), 0);

      chk("onehot_pulses", n_multi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Command sequencer that sits directly upstream of the 4-bit `shift_register`. It accepts load and shift commands over a valid/ready handshake and buffers them in a small FIFO. It then drives the register's `d_in`, `ld`, `sl` and `sr` inputs with correctly sequenced one-cycle pulses, repeating shifts as many times as each command requests. Its outputs connect port-for-port to the shift register's control and data inputs.

## Interface
- `WIDTH`, 4: data width; matches the shift register.
- `DEPTH`, 4: command FIFO depth; must be a power of two, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; empties the FIFO and aborts the current command.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command; equals !full.
- `cmd_op`  in  2  0=NOP, 1=LOAD, 2=SHL, 3=SHR.
- `cmd_data`  in  WIDTH  load value; used by LOAD only.
- `cmd_count`  in  4  number of shift pulses, 0–15; used by SHL/SHR only.
- `d_in`  out  WIDTH  data to the shift register.
- `ld`, `sl`, `sr`  out  1 each  one-cycle control pulses; at most one is high in any cycle.
- `busy`  out  1  high when the FSM is in EXEC or the FIFO is non-empty.
- `done`  out  1  one-cycle pulse in the final cycle of each command.

## Operation
- Push: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. The command fields are written into the FIFO at that edge.
- There is no bypass: a command pushed into an empty FIFO is popped no earlier than the following edge.
- FSM states: IDLE and EXEC.
- IDLE:
  - If the FIFO is non-empty, pop the head into working registers (op, data, remaining count) and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC, NOP: no pulses; `done`=1; go to IDLE.
- EXEC, LOAD:
  - `d_in` register is loaded with `cmd_data` at the pop edge.
  - `ld`=1 and `done`=1 for one cycle; go to IDLE.
- EXEC, SHL/SHR:
  - Each EXEC cycle asserts `sl` (SHL) or `sr` (SHR) and decrements the remaining count.
  - `done` is asserted together with the last pulse; go to IDLE.
  - A count of 0 produces no pulse: `done`=1 in a single EXEC cycle.
- `d_in` keeps its last LOAD value. Shifts and NOPs never change it.
- `ld`, `sl`, `sr` and `done` are decoded only from registered state. There is no combinational path from any `cmd_*` input to any output.
- Push while popping: allowed whenever `cmd_ready`=1. Occupancy is unchanged.
- FIFO full: `cmd_ready`=0. A pop in that cycle does not raise `cmd_ready` until the next cycle.
- `flush`:
  - On the next edge, the FIFO is emptied, the FSM goes to IDLE and the remaining count is cleared.
  - A push in the same cycle is discarded.
  - The command in progress gets no `done` pulse.
  - `d_in` is kept.
- `reset`: asynchronous and active-high; it takes effect immediately, including in the middle of a command.

## Timing
- Reset values: `d_in`=0, `ld`=`sl`=`sr`=0, `done`=0, `busy`=0, `cmd_ready`=1, FSM in IDLE, FIFO empty.
- Latency from a push at edge t0 to the first pulse:
  - pop at edge t1;
  - first `ld`/`sl`/`sr` high during the cycle after t1, i.e. 2 cycles.
- A shift with count N occupies N EXEC cycles (1 cycle if N=0), with pulses back-to-back.
- Between consecutive commands there is exactly one IDLE cycle (the pop cycle).
- Sustained throughput is one command per (EXEC cycles + 1).
- `busy` falls in the first cycle that has both an empty FIFO and state IDLE.

## Structure
- Package `shift_cmd_pkg`:
  - op encodings `OP_NOP`, `OP_LOAD`, `OP_SHL`, `OP_SHR`;
  - FSM state encodings `S_IDLE`, `S_EXEC`;
  - command record width `CMD_W = 2 + WIDTH + 4`.
- Sub-module `cmd_fifo`:
  - synchronous FIFO of `DEPTH` × `CMD_W`, with `push`, `pop`, `flush`, `full` and `empty`;
  - pointer-based, one extra pointer bit to distinguish full from empty;
  - pointers wrap modulo `DEPTH`.
- The top level holds the FSM, the working registers, the `d_in` register and the output decode.

## Test plan
- Reset then LOAD 4'b1011: `ld` high exactly 1 cycle, 2 cycles after the push; `d_in`=1011 during and after the pulse; `done` in the same cycle as `ld`.
- LOAD 1011, then SHL count 1, then SHR count 1, pushed back-to-back:
  - pulse order is `ld`, bubble, `sl`, bubble, `sr`;
  - the downstream `shift_register` output goes 1011, 0110, 0011 (zero fill).
- SHR count 3: `sr` high on 3 consecutive cycles, `done` on the 3rd; SHL count 0: no pulse, `done` after 1 EXEC cycle.
- Hold `cmd_valid` with `DEPTH`+2 commands while the sequencer is busy: `cmd_ready` drops at 4 queued; no command is lost or duplicated; execution order is FIFO order; pointers wrap correctly.
- `flush` in the middle of SHL count 10 with 2 commands queued: pulses stop at the next edge; no `done`; `busy`=0 the cycle after; `d_in` unchanged.
- Assert `reset` in the middle of a shift, not aligned to an edge: outputs go to their reset values immediately, the FIFO is empty, and `cmd_ready`=1.
